// File: rtl/encoder4to2_pkg.sv
// Shared widths, handshake state type and a one-hot helper for the 4-line event encoder.
package encoder4to2_pkg;

  localparam int N_LINES = 4;
  localparam int CODE_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [N_LINES-1:0] onehot(input logic [CODE_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/encoder4to2_prio_sel4.sv
// Combinational 4-way selector; default searches downward from start, ENCODER4TO2_ROUND_ROBIN_EN
// searches upward from start with wrap.
module prio_sel4
  import encoder4to2_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  input  logic [CODE_W-1:0]  start,
  output logic [CODE_W-1:0]  idx,
  output logic               any
);

  logic [CODE_W-1:0] cand;
  logic              found;

  always_comb begin
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N_LINES; i++) begin
`ifdef ENCODER4TO2_ROUND_ROBIN_EN
      cand = start + CODE_W'(i);
`else
      cand = start - CODE_W'(i);
`endif
      if (!found && vec[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/encoder4to2_event.sv
// Sticky event capture with a one-deep valid/ready output slot; ENCODER4TO2_ROUND_ROBIN_EN
// switches from fixed highest-index priority to a rotating pointer.
//   state | meaning
//   IDLE  | no granted event, valid=0
//   HOLD  | code holds a granted event, valid=1 until ready
module encoder4to2_event
  import encoder4to2_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_LINES-1:0] req,
  input  logic               ready,
  output logic [CODE_W-1:0]  code,
  output logic               valid,
  output logic [N_LINES-1:0] pending,
  output logic               overflow
);

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [N_LINES-1:0] pending_q, pending_d;
  logic               overflow_q, overflow_d;
  logic [CODE_W-1:0]  sel_idx, start_idx;
  logic               sel_any, load;
  logic [N_LINES-1:0] clr, set_v;

`ifdef ENCODER4TO2_ROUND_ROBIN_EN
  logic [CODE_W-1:0] ptr_q, ptr_d;
  assign start_idx = ptr_q;
  assign ptr_d     = load ? sel_idx + CODE_W'(1) : ptr_q;
`else
  assign start_idx = CODE_W'(N_LINES - 1);
`endif

  prio_sel4 u_sel (
    .vec   (pending_q),
    .start (start_idx),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // Selection sees only registered pending; same-cycle req lands next cycle.
  always_comb begin
    load       = ((state_q == IDLE) || ready) && sel_any;
    clr        = load ? onehot(sel_idx) : '0;
    set_v      = en ? req : '0;
    pending_d  = (pending_q & ~clr) | set_v;
    overflow_d = |(set_v & pending_q & ~clr);
    code_d     = load ? sel_idx : code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      code_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef ENCODER4TO2_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = HOLD;
      HOLD:    if (ready) state_d = load ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid    = (state_q == HOLD);
    code     = code_q;
    pending  = pending_q;
    overflow = overflow_q;
  end

endmodule
